// File: rtl/freq_pkg.sv
// Shared types and constants for the frequency-meter gate sequencer.
package freq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_GATE,
    S_STORE,
    S_HOLD
  } gate_state_t;

  localparam logic [1:0] RANGE_1S    = 2'd0;
  localparam logic [1:0] RANGE_100MS = 2'd1;
  localparam logic [1:0] RANGE_10MS  = 2'd2;

  function automatic logic [1:0] range_clamp(input logic [1:0] r);
    return (r == 2'd3) ? RANGE_10MS : r;
  endfunction

endpackage

// File: rtl/gate_ctrl_tick_timer.sv
// tick_timer: loadable down-counter; tc is high while the count equals 1.
module tick_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == W'(1));

endmodule

// File: rtl/gate_ctrl.sv
// gate_ctrl: clear -> gate -> store -> hold measurement sequencer.
// Build option GATE_AUTORANGE_EN selects auto-ranging from ovf/count_low.
module gate_ctrl
  import freq_pkg::*;
#(
  parameter int unsigned CP_HZ       = 1000,
  parameter int unsigned GATE0_TICKS = 1000,
  parameter int unsigned GATE1_TICKS = 100,
  parameter int unsigned GATE2_TICKS = 10,
  parameter int unsigned HOLD_TICKS  = 500
) (
  input  logic       CP,
  input  logic       RST,
  input  logic       RUN,
  input  logic       ovf,
  input  logic       count_low,
  input  logic [1:0] range_sel,
  output logic       C_Clear,
  output logic       C_Enable,
  output logic       C_Store,
  output logic [1:0] Status_Value,
  output logic       busy,
  output logic       range_chg
);

  localparam int unsigned MAX_G01 = (GATE0_TICKS > GATE1_TICKS) ? GATE0_TICKS : GATE1_TICKS;
  localparam int unsigned MAX_G   = (MAX_G01 > GATE2_TICKS) ? MAX_G01 : GATE2_TICKS;
  localparam int unsigned MAX_T   = (MAX_G > HOLD_TICKS) ? MAX_G : HOLD_TICKS;
  localparam int unsigned TW      = $clog2(MAX_T) + 1;

  gate_state_t   state_q, state_d;
  logic [1:0]    range_q, range_d;
  logic [1:0]    gate_range;
  logic [TW-1:0] gate_len, load_val;
  logic          tmr_load, tmr_en, tmr_tc;
  logic          unused_ok;

  always_comb begin
    case (gate_range)
      RANGE_1S:    gate_len = TW'(GATE0_TICKS);
      RANGE_100MS: gate_len = TW'(GATE1_TICKS);
      default:     gate_len = TW'(GATE2_TICKS);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    load_val = gate_len;
    case (state_q)
      S_IDLE:  if (RUN) state_d = S_CLEAR;
      S_CLEAR: begin
        tmr_load = 1'b1;
        state_d  = S_GATE;
      end
      S_GATE: begin
        tmr_en = 1'b1;
        if (tmr_tc) state_d = S_STORE;
      end
      S_STORE: begin
        tmr_load = 1'b1;
        load_val = TW'(HOLD_TICKS);
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        tmr_en = 1'b1;
        if (tmr_tc) state_d = RUN ? S_CLEAR : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef GATE_AUTORANGE_EN
  logic ovf_seen_q, ovf_seen_d;
  logic chg_q, chg_d;

  assign gate_range = range_q;

  // Overflow takes priority over low-count when both request a move.
  always_comb begin
    ovf_seen_d = ovf_seen_q;
    range_d    = range_q;
    chg_d      = 1'b0;
    case (state_q)
      S_CLEAR: ovf_seen_d = 1'b0;
      S_GATE:  ovf_seen_d = ovf_seen_q | ovf;
      S_STORE: begin
        if (ovf_seen_q && (range_q < RANGE_10MS)) begin
          range_d = range_q + 2'd1;
        end else if (count_low && (range_q > RANGE_1S)) begin
          range_d = range_q - 2'd1;
        end
        chg_d = (range_d != range_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      ovf_seen_q <= 1'b0;
      chg_q      <= 1'b0;
    end else begin
      ovf_seen_q <= ovf_seen_d;
      chg_q      <= chg_d;
    end
  end

  assign range_chg = chg_q;
  assign unused_ok = ^range_sel ^ CP_HZ[0];
`else
  logic [1:0] sel_clamped;

  assign sel_clamped = range_clamp(range_sel);
  // The gate length loaded in CLEAR already follows the newly sampled range.
  assign gate_range  = (state_q == S_CLEAR) ? sel_clamped : range_q;

  always_comb begin
    range_d = range_q;
    if (state_q == S_CLEAR) range_d = sel_clamped;
  end

  assign range_chg = (state_q == S_CLEAR) && (sel_clamped != range_q);
  assign unused_ok = ovf ^ count_low ^ CP_HZ[0];
`endif

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      range_q <= RANGE_1S;
    end else begin
      state_q <= state_d;
      range_q <= range_d;
    end
  end

  tick_timer #(.W(TW)) u_tick_timer (
    .clk      (CP),
    .rst      (RST),
    .load     (tmr_load),
    .load_val (load_val),
    .en       (tmr_en),
    .tc       (tmr_tc)
  );

  assign C_Clear      = (state_q == S_CLEAR);
  assign C_Enable     = (state_q == S_GATE);
  assign C_Store      = (state_q == S_STORE);
  assign busy         = (state_q != S_IDLE);
  assign Status_Value = range_q;

endmodule

// File: tb/tb_gate_ctrl.sv
// Randomized bench for gate_ctrl: a per-measurement timeline model predicts
// every output on every clock; works with or without GATE_AUTORANGE_EN.
module tb_gate_ctrl;

  localparam int G0 = 24;
  localparam int G1 = 9;
  localparam int G2 = 2;
  localparam int H  = 3;

`ifdef GATE_AUTORANGE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, run, ovf, count_low;
  logic [1:0] range_sel;
  logic       c_clear, c_enable, c_store, busy, range_chg;
  logic [1:0] status_value;

  int n_checks = 0;
  int n_fail   = 0;
  int m_range  = 0;

  always #5 clk = ~clk;

  gate_ctrl #(
    .CP_HZ       (1000),
    .GATE0_TICKS (G0),
    .GATE1_TICKS (G1),
    .GATE2_TICKS (G2),
    .HOLD_TICKS  (H)
  ) dut (
    .CP           (clk),
    .RST          (rst),
    .RUN          (run),
    .ovf          (ovf),
    .count_low    (count_low),
    .range_sel    (range_sel),
    .C_Clear      (c_clear),
    .C_Enable     (c_enable),
    .C_Store      (c_store),
    .Status_Value (status_value),
    .busy         (busy),
    .range_chg    (range_chg)
  );

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_out(input string ph, input int clr, input int en, input int st,
                           input int bsy, input int status, input int chg);
    check({ph, ".C_Clear"},      c_clear,      clr);
    check({ph, ".C_Enable"},     c_enable,     en);
    check({ph, ".C_Store"},      c_store,      st);
    check({ph, ".busy"},         busy,         bsy);
    check({ph, ".Status_Value"}, status_value, status);
    check({ph, ".range_chg"},    range_chg,    chg);
  endtask

  function automatic int gate_len(input int r);
    return (r == 0) ? G0 : (r == 1) ? G1 : G2;
  endfunction

  task automatic idle_cycle(input bit r);
    @(negedge clk);
    rst       = 1'b0;
    run       = r;
    ovf       = 1'($urandom_range(0, 1));
    count_low = 1'($urandom_range(0, 1));
    range_sel = 2'($urandom_range(0, 3));
    #1;
    check_out("idle", 0, 0, 0, 0, m_range, 0);
  endtask

  // One full measurement starting in CLEAR; optionally aborted by reset mid-gate.
  task automatic measure(input bit do_abort, input bit next_run);
    int sel, nr, gl, mode, abort_at;
    bit seen, cl, chg;

    @(negedge clk);
    sel       = $urandom_range(0, 3);
    range_sel = 2'(sel);
    ovf       = 1'($urandom_range(0, 1));
    count_low = 1'($urandom_range(0, 1));
    run       = 1'($urandom_range(0, 1));
    #1;
    nr = AUTO ? m_range : ((sel > 2) ? 2 : sel);
    check_out("clear", 1, 0, 0, 1, m_range, int'(nr != m_range));
    m_range = nr;

    gl       = gate_len(m_range);
    mode     = $urandom_range(0, 2);
    abort_at = do_abort ? $urandom_range(0, gl - 1) : -1;
    seen     = 1'b0;
    for (int i = 0; i < gl; i++) begin
      @(negedge clk);
      range_sel = 2'($urandom_range(0, 3));
      run       = 1'($urandom_range(0, 1));
      count_low = 1'($urandom_range(0, 1));
      case (mode)
        0:       ovf = 1'b0;
        1:       ovf = (i == gl - 1);
        default: ovf = ($urandom_range(0, 15) == 0);
      endcase
      if (i == abort_at) begin
        rst = 1'b1;
        #1;
        m_range = 0;
        check_out("abort", 0, 0, 0, 0, m_range, 0);
        return;
      end
      #1;
      check_out("gate", 0, 1, 0, 1, m_range, 0);
      seen |= ovf;
    end

    @(negedge clk);
    cl        = 1'($urandom_range(0, 1));
    count_low = cl;
    ovf       = 1'($urandom_range(0, 1));
    run       = 1'($urandom_range(0, 1));
    #1;
    check_out("store", 0, 0, 1, 1, m_range, 0);
    nr = m_range;
    if (AUTO) begin
      if (seen && m_range < 2) nr = m_range + 1;
      else if (cl && m_range > 0) nr = m_range - 1;
    end
    chg     = (nr != m_range);
    m_range = nr;

    for (int j = 0; j < H; j++) begin
      @(negedge clk);
      ovf       = 1'($urandom_range(0, 1));
      count_low = 1'($urandom_range(0, 1));
      run       = (j == H - 1) ? next_run : 1'($urandom_range(0, 1));
      #1;
      check_out("hold", 0, 0, 0, 1, m_range, int'((j == 0) && chg));
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit nr, ab;
    rst       = 1'b1;
    run       = 1'b0;
    ovf       = 1'b0;
    count_low = 1'b0;
    range_sel = 2'd0;
    repeat (2) begin
      @(negedge clk);
      #1;
      check_out("reset", 0, 0, 0, 0, 0, 0);
    end
    repeat (3) idle_cycle(1'b0);
    idle_cycle(1'b1);

    for (int k = 0; k < 60; k++) begin
      ab = (k == 12) || (k == 31) || (k == 47);
      nr = ($urandom_range(0, 3) != 0);
      measure(ab, nr);
      if (ab) begin
        idle_cycle(1'b1);
      end else if (!nr) begin
        repeat ($urandom_range(1, 3)) idle_cycle(1'b0);
        idle_cycle(1'b1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_ctrl.md
# gate_ctrl

Measurement sequencer for the frequency meter. It drives the counter stage's `C_Clear`, `C_Enable` and `C_Store` controls and its 2-bit `Status_Value` range code. It runs a continuous clear → gate → store → hold cycle from a reference tick clock. Optionally, it auto-ranges the gate length from the counter's overflow and low-count flags.

## Interface
- `CP_HZ`, 1000: frequency of `CP` in Hz.
- `GATE0_TICKS`, 1000: gate length for range 0 (1 s at 1 kHz).
- `GATE1_TICKS`, 100: gate length for range 1 (100 ms).
- `GATE2_TICKS`, 10: gate length for range 2 (10 ms).
- `HOLD_TICKS`, 500: display-hold length after store, in ticks (must be ≥1).

Ports:
- `CP` input 1: reference tick clock; all logic on the rising edge.
- `RST` input 1: asynchronous reset, active high.
- `RUN` input 1: continuous measurement enable.
- `ovf` input 1: counter overflow flag, valid during GATE.
- `count_low` input 1: stored result below 1000, valid in the STORE cycle.
- `range_sel` input 2: manual range; used only without auto-range.
- `C_Clear` output 1: one-cycle counter clear pulse.
- `C_Enable` output 1: counting gate.
- `C_Store` output 1: one-cycle latch pulse.
- `Status_Value` output 2: current range code, 0..2.
- `busy` output 1: high in any state except IDLE.
- `range_chg` output 1: one-cycle pulse when `Status_Value` changes.

## Operation
- States: IDLE, CLEAR, GATE, STORE, HOLD.
- **IDLE:** all strobes low. Move to CLEAR on `RUN`=1.
- **CLEAR:** 1 cycle, `C_Clear`=1.
  - Gate tick counter loads the length for the current range.
  - Without auto-range, `Status_Value` takes `range_sel`; value 3 clamps to 2.
  - Moves to GATE.
- **GATE:** `C_Enable`=1 for exactly the selected tick count, then STORE.
  - `ovf` is sticky into `ovf_seen` while in GATE.
  - `ovf_seen` clears in CLEAR.
- **STORE:** 1 cycle, `C_Store`=1. The range decision is made here (auto-range only):
  - `ovf_seen`=1 and `Status_Value`<2: increment (shorter gate).
  - Otherwise, `count_low`=1 and `Status_Value`>0: decrement (longer gate).
  - If both conditions hold, overflow wins.
  - A new value is registered on the STORE→HOLD edge.
  - `range_chg` pulses in the first HOLD cycle.
- **HOLD:** lasts `HOLD_TICKS` cycles.
  - At the end: CLEAR if `RUN`=1, else IDLE.
  - `RUN` dropping earlier never truncates a CLEAR, GATE, STORE or HOLD in progress; the cycle always completes.
- Tick counter width is `$clog2` of the largest of the gate/hold tick values, plus 1. It counts down and reaches the terminal value at 1.
- At most one of `C_Clear`, `C_Enable`, `C_Store` is high in any cycle.

## Timing
- Reset values: state IDLE; all strobes 0; `Status_Value`=0; `busy`=0; `range_chg`=0; `ovf_seen`=0.
- Reset asserted mid-cycle aborts immediately. The counter stage then sees `C_Enable` fall with no `C_Store`.
- `RUN` sampled in IDLE: `C_Clear` is high in the next cycle.
- For range r, one full cycle is 1 + GATEr + 1 + HOLD_TICKS clocks.
- `C_Enable` rises the cycle after `C_Clear` and falls the cycle `C_Store` rises.
- `ovf` asserted in the final GATE cycle is still captured.
- `ovf` asserted in STORE or HOLD is ignored.

## Configuration
- Macro: `GATE_AUTORANGE_EN`.
- **Defined:**
  - Auto-ranging as above.
  - `range_sel` is ignored.
  - `Status_Value` starts at 0 after reset and changes only in STORE.
- **Undefined:**
  - No range decision logic.
  - `Status_Value` follows `range_sel` (clamped), sampled in CLEAR only.
  - `range_chg` pulses in the CLEAR cycle when the sampled value differs from the previous one.
  - `ovf` and `count_low` are unused.

## Structure
- Shared package `freq_pkg`:
  - State enum `gate_state_t`.
  - Range constants `RANGE_1S`=0, `RANGE_100MS`=1, `RANGE_10MS`=2.
  - Function `range_clamp` (3→2).
- One sub-module, `tick_timer`: loadable down-counter with a terminal-count output, used for both gate and hold intervals.
- The FSM and the range register live in `gate_ctrl`.

## Test plan
- **Reset and start:** RST pulse, then `RUN`=1 → `C_Clear` 1 cycle, `C_Enable` exactly 1000 cycles, `C_Store` 1 cycle, 500 hold cycles; repeats with period 1502.
- **Overflow up-range (auto):** `ovf` pulsed in the last GATE cycle → `Status_Value` 0→1 with a `range_chg` pulse; the next gate is 100 cycles. Repeat → 2; a third overflow → stays 2, no pulse.
- **Low-count down-range with conflict:** at range 2, `count_low`=1 in STORE → 1. At range 1, `ovf`+`count_low` both set → goes to 2.
- **RUN drop mid-GATE:** `RUN`=0 at gate cycle 50 → gate completes, STORE and HOLD occur, then IDLE with `busy`=0.
- **Async reset mid-GATE:** RST at gate cycle 300 → all outputs 0 in the same cycle; `Status_Value`=0; restarts from CLEAR after release.
- **Manual mode (macro undefined):** `range_sel`=3 → `Status_Value`=2, gate 10 cycles. A `range_sel` change during GATE → no effect until the next CLEAR.
